// File: rtl/atetris_pkg.sv
// Shared types for the atetris emu glue.
// NVRAM sequencer state and ioctl constants.
package atetris_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACTIVE,
    DONE
  } nvm_state_t;

  localparam logic [7:0] NVM_INDEX = 8'd4;
  localparam int IOCTL_AW = 25;

  function automatic logic in_range(
    input logic [IOCTL_AW-1:0] a,
    input int aw
  );
    return (a >> aw) == '0;
  endfunction

endpackage

// File: rtl/nvram_access_ctrl_if.sv
// HPS ioctl bus and core NVRAM port bundles.
// master drives the request side of each bus.
interface ioctl_if;
  import atetris_pkg::*;

  logic                ioctl_download;
  logic                ioctl_upload;
  logic [7:0]          ioctl_index;
  logic                ioctl_wr;
  logic                ioctl_rd;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0]          ioctl_dout;
  logic [7:0]          ioctl_din;
  logic                ioctl_wait;

  modport master (
    output ioctl_download, ioctl_upload,
    output ioctl_index, ioctl_wr, ioctl_rd,
    output ioctl_addr, ioctl_dout,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_download, ioctl_upload,
    input  ioctl_index, ioctl_wr, ioctl_rd,
    input  ioctl_addr, ioctl_dout,
    output ioctl_din, ioctl_wait
  );
endinterface

interface hs_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] hs_address;
  logic [7:0]        hs_data_in;
  logic              hs_write;
  logic [7:0]        hs_data_out;

  modport master (
    output hs_address, hs_data_in, hs_write,
    input  hs_data_out
  );

  modport slave (
    input  hs_address, hs_data_in, hs_write,
    output hs_data_out
  );
endinterface

// File: rtl/nvram_access_ctrl.sv
// Arbitrates HPS NVRAM load/save against the running game.
// Pauses the core, settles, then owns the hs_* port.
module nvram_access_ctrl
  import atetris_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int SETTLE = 8
) (
  input  logic   clk_sys,
  input  logic   RESET,
  ioctl_if.slave ioctl,
  hs_if.master   hs,
  input  logic   user_pause,
  output logic   pause,
  output logic   busy,
  output logic   ovf
);

  nvm_state_t        state;
  logic [7:0]        cnt;
  logic              first;
  logic              hold_vld;
  logic              hold_ok;
  logic [ADDR_W-1:0] hold_addr;
  logic [7:0]        hold_data;
  logic [1:0]        rd_ph;
  logic              rd_ok;

  logic sel;
  logic wr_req;
  logic rd_req;
  logic addr_ok;

  assign sel = (ioctl.ioctl_download
             | ioctl.ioctl_upload)
             & (ioctl.ioctl_index == NVM_INDEX);

  assign wr_req = sel & ioctl.ioctl_download
                & ioctl.ioctl_wr;
  assign rd_req = sel & ioctl.ioctl_upload
                & ioctl.ioctl_rd;
  assign addr_ok = in_range(ioctl.ioctl_addr,
                            ADDR_W);

  assign busy  = (state != IDLE);
  assign pause = user_pause | busy;

  // hold pending after the replay cycle means a write collided
  assign ioctl.ioctl_wait =
      (state == REQ)
    | (rd_ph != 2'd0)
    | ((state == ACTIVE) && hold_vld && !first);

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state            <= IDLE;
      cnt              <= '0;
      first            <= 1'b0;
      hold_vld         <= 1'b0;
      hold_ok          <= 1'b0;
      hold_addr        <= '0;
      hold_data        <= '0;
      ovf              <= 1'b0;
      rd_ph            <= 2'd0;
      rd_ok            <= 1'b0;
      hs.hs_write      <= 1'b0;
      hs.hs_address    <= '0;
      hs.hs_data_in    <= '0;
      ioctl.ioctl_din  <= '0;
    end else begin
      hs.hs_write <= 1'b0;

      if (wr_req) begin
        hold_ok   <= addr_ok;
        hold_addr <= ioctl.ioctl_addr[ADDR_W-1:0];
        hold_data <= ioctl.ioctl_dout;
      end

      if (rd_ph == 2'd2) begin
        ioctl.ioctl_din <= rd_ok ? hs.hs_data_out
                                 : 8'hFF;
        rd_ph <= 2'd0;
      end else if (rd_ph == 2'd1) begin
        rd_ph <= 2'd2;
      end

      unique case (state)
        IDLE: begin
          if (sel) begin
            state    <= REQ;
            cnt      <= 8'(SETTLE - 1);
            hold_vld <= wr_req;
          end
        end
        REQ: begin
          if (!sel) begin
            state    <= DONE;
            hold_vld <= 1'b0;
          end else begin
            if (wr_req) begin
              hold_vld <= 1'b1;
              if (hold_vld) ovf <= 1'b1;
            end
            if (cnt == 8'd0) begin
              state <= ACTIVE;
              first <= 1'b1;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        ACTIVE: begin
          first <= 1'b0;
          // held byte goes first; a new one waits a cycle
          if (hold_vld) begin
            hold_vld <= wr_req;
            if (hold_ok) begin
              hs.hs_write   <= 1'b1;
              hs.hs_address <= hold_addr;
              hs.hs_data_in <= hold_data;
            end
          end else if (wr_req && addr_ok) begin
            hs.hs_write   <= 1'b1;
            hs.hs_address <=
              ioctl.ioctl_addr[ADDR_W-1:0];
            hs.hs_data_in <= ioctl.ioctl_dout;
          end
          if (rd_req && rd_ph == 2'd0) begin
            rd_ph <= 2'd1;
            rd_ok <= addr_ok;
            if (addr_ok) begin
              hs.hs_address <=
                ioctl.ioctl_addr[ADDR_W-1:0];
            end
          end
          if (!sel) state <= DONE;
        end
        DONE: begin
          state    <= IDLE;
          hold_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule
